// File: rtl/goose_audio_seq.sv
// goose_audio_seq
//   Sequences a fixed 8-note "OIIA" loop from an internal note ROM and drives
//   the 1-bit audio line that feeds uio_out[7] in tt_um_goose. Each note is a
//   square wave whose half period is counted in clk cycles; a rest entry
//   (half period 0) keeps the line low for the whole note.
//
// Ports
//   clk        pixel clock, the block's only clock
//   rst_n      asynchronous active-low reset
//   en         level-sensitive play enable; dropping it returns to IDLE
//   audio_out  registered square/PWM audio
//   note_idx   index of the current ROM entry
//   playing    high while the sequencer is in LOAD, PLAY or GAP
//
// Optional build macro: AUDIO_DECAY_EN
//   When defined, each note starts at volume 15 and decays by one step every
//   4th tick (floor 1). The square is gated by a free-running 4-bit PWM
//   compare against the volume. Ports, FSM and timing are the same in both
//   builds.
module goose_audio_seq #(
  parameter int TICK_DIV  = 250000,
  parameter int GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       audio_out,
  output logic [2:0] note_idx,
  output logic       playing
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   half_period;
  logic [15:0]   hp_cnt;
  logic [5:0]    dur_cnt;
  logic [GW-1:0] gap_cnt;
  logic          square;
  logic          hp_wrap;
  logic          last_tick;
  logic          gap_done;
  logic          audio_d;
  logic [21:0]   rom_entry;

  // Note ROM: {half_period[15:0], dur_ticks[5:0]}
  function automatic logic [21:0] note_rom(input logic [2:0] idx);
    logic [21:0] e;
    case (idx)
      3'd0:    e = {16'd28409, 6'd20};
      3'd1:    e = {16'd0,     6'd5};
      3'd2:    e = {16'd28409, 6'd20};
      3'd3:    e = {16'd0,     6'd5};
      3'd4:    e = {16'd21282, 6'd20};
      3'd5:    e = {16'd25310, 6'd20};
      3'd6:    e = {16'd28409, 6'd40};
      default: e = {16'd0,     6'd10};
    endcase
    return e;
  endfunction

  assign rom_entry = note_rom(note_idx);
  assign playing   = (state != IDLE);
  assign tick      = (state != IDLE) && (tick_cnt == TW'(TICK_DIV - 1));
  assign hp_wrap   = (half_period != 16'd0) && (hp_cnt == half_period - 16'd1);
  assign last_tick = tick && (dur_cnt == 6'd1);
  assign gap_done  = tick && (gap_cnt == GW'(GAP_TICKS - 1));

  // Next-state logic; en low wins from every state
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = LOAD;
        LOAD:    state_next = PLAY;
        PLAY:    if (last_tick) state_next = GAP;
        GAP:     if (gap_done) state_next = LOAD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Tick divider: held at 0 in IDLE so every start is phase-aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   tick_cnt <= '0;
    else if (state == IDLE || state_next == IDLE) tick_cnt <= '0;
    else if (tick)                                tick_cnt <= '0;
    else                                          tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     note_idx <= 3'd0;
    else if (state_next == IDLE)                    note_idx <= 3'd0;
    else if (state == GAP && state_next == LOAD)    note_idx <= note_idx + 3'd1;
  end

  // Note datapath: latch ROM entry, half-period counter, duration, gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_period <= 16'd0;
      hp_cnt      <= 16'd0;
      dur_cnt     <= 6'd0;
      gap_cnt     <= '0;
      square      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          half_period <= rom_entry[21:6];
          dur_cnt     <= rom_entry[5:0];
          // The LOAD cycle is count 0, so the first toggle lands
          // half_period cycles after entering LOAD.
          hp_cnt      <= 16'd1;
          square      <= 1'b0;
          gap_cnt     <= '0;
        end
        PLAY: begin
          if (hp_wrap) begin
            hp_cnt <= 16'd0;
            square <= ~square;
          end else if (half_period != 16'd0) begin
            hp_cnt <= hp_cnt + 16'd1;
          end
          if (tick) dur_cnt <= dur_cnt - 6'd1;
          gap_cnt <= '0;
        end
        GAP: begin
          hp_cnt <= 16'd0;
          square <= 1'b0;
          if (tick) gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          hp_cnt  <= 16'd0;
          square  <= 1'b0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

`ifdef AUDIO_DECAY_EN
  logic [3:0] volume;
  logic [1:0] vol_tick;
  logic [3:0] pwm_cnt;

  function automatic logic [3:0] vol_dec(input logic [3:0] v);
    return (v > 4'd1) ? v - 4'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      volume   <= 4'd0;
      vol_tick <= 2'd0;
      pwm_cnt  <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (state == LOAD) begin
        volume   <= 4'd15;
        vol_tick <= 2'd0;
      end else if (state == PLAY && tick) begin
        vol_tick <= vol_tick + 2'd1;
        if (vol_tick == 2'd3) volume <= vol_dec(volume);
      end
    end
  end

  assign audio_d = square & (pwm_cnt < volume);
`else
  assign audio_d = square;
`endif

  // Output register: anything but a continuing PLAY forces silence on the
  // same edge, so GAP and the en-drop edge are always quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  audio_out <= 1'b0;
    else if (state_next == PLAY) audio_out <= audio_d;
    else                         audio_out <= 1'b0;
  end

endmodule

// File: tb/tb_goose_audio_seq.sv
// Directed bench for goose_audio_seq. A short-tick instance (TICK_DIV=10)
// checks sequencing, rests, loop wrap, en drop and reset; a long-tick
// instance (TICK_DIV=2000) keeps note 0 long enough to see the first
// square edge and the high-phase duty.
module tb_goose_audio_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       en_l;
  logic       audio_out, audio_l;
  logic [2:0] note_idx, note_l;
  logic       playing, playing_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  goose_audio_seq #(.TICK_DIV(10), .GAP_TICKS(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .audio_out(audio_out), .note_idx(note_idx), .playing(playing)
  );

  goose_audio_seq #(.TICK_DIV(2000), .GAP_TICKS(1)) dut_long (
    .clk(clk), .rst_n(rst_n), .en(en_l),
    .audio_out(audio_l), .note_idx(note_l), .playing(playing_l)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs the short instance until note_idx changes (bounded).
  task automatic run_note(output int cycles, output int highs, output int idle_seen);
    logic [2:0] start;
    start = note_idx;
    cycles = 0;
    highs = 0;
    idle_seen = 0;
    do begin
      step(1);
      cycles++;
      if (audio_out) highs++;
      if (!playing) idle_seen++;
    end while (note_idx == start && cycles < 1000);
  endtask

  // Cycles from the LOAD edge to the first audio_l high (-1 if none).
  task automatic measure_rise(output int rise);
    rise = -1;
    for (int c = 1; c <= 30000; c++) begin
      step(1);
      if (audio_l) begin
        rise = c;
        break;
      end
    end
  endtask

  task automatic check_rise(input string tag, input int rise);
`ifdef AUDIO_DECAY_EN
    chk(tag, int'(rise >= 28410 && rise <= 28425), 1);
`else
    chk(tag, rise, 28410);
`endif
  endtask

  int note_cycles [8] = '{210, 60, 210, 60, 210, 210, 410, 110};

  initial begin
    int cyc, hi, lo, total, hi_sum, lo_sum, rise, win;

    rst_n = 1'b0;
    en    = 1'b0;
    en_l  = 1'b0;
    step(2);
    chk("rst_audio", audio_out, 0);
    chk("rst_note", note_idx, 0);
    chk("rst_playing", playing, 0);
    rst_n = 1'b1;
    step(3);
    chk("idle_playing", playing, 0);

    // Start from IDLE and play one full loop
    en = 1'b1;
    step(1);
    chk("load_playing", playing, 1);
    chk("load_note", note_idx, 0);
    total = 0;
    hi_sum = 0;
    lo_sum = 0;
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("loop_note%0d_idx", n), note_idx, n);
      run_note(cyc, hi, lo);
      chk($sformatf("loop_note%0d_cycles", n), cyc, note_cycles[n]);
      total += cyc;
      hi_sum += hi;
      lo_sum += lo;
    end
    chk("loop_wrap_idx", note_idx, 0);
    chk("loop_total_cycles", total, 1480);
    chk("loop_audio_highs", hi_sum, 0);
    chk("loop_playing_low", lo_sum, 0);

    // Drop en in the middle of note 4
    for (int n = 0; n < 4; n++) run_note(cyc, hi, lo);
    chk("pre_drop_note", note_idx, 4);
    step(50);
    en = 1'b0;
    step(1);
    chk("drop_audio", audio_out, 0);
    chk("drop_note", note_idx, 0);
    chk("drop_playing", playing, 0);
    step(5);
    chk("drop_hold_playing", playing, 0);
    en = 1'b1;
    step(1);
    chk("restart_playing", playing, 1);
    chk("restart_note", note_idx, 0);
    run_note(cyc, hi, lo);
    chk("restart_note0_cycles", cyc, 210);
    chk("restart_note1_idx", note_idx, 1);

    // Asynchronous reset in the middle of note 4
    for (int n = 1; n < 4; n++) run_note(cyc, hi, lo);
    step(30);
    chk("pre_rst_note", note_idx, 4);
    rst_n = 1'b0;
    #2;
    chk("async_rst_audio", audio_out, 0);
    chk("async_rst_note", note_idx, 0);
    chk("async_rst_playing", playing, 0);
    en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_note", note_idx, 0);
    chk("post_rst_playing", playing, 0);
    en = 1'b1;
    step(1);
    chk("post_rst_start", playing, 1);
    en = 1'b0;
    step(1);

    // Long-tick instance: first square edge and high-phase duty
    en_l = 1'b1;
    step(1);
    chk("long_load_playing", playing_l, 1);
    chk("long_load_audio", audio_l, 0);
    measure_rise(rise);
    check_rise("long_first_rise", rise);
    win = 0;
    for (int i = 0; i < 16; i++) begin
      if (audio_l) win++;
      step(1);
    end
`ifdef AUDIO_DECAY_EN
    chk("long_duty_highs", win, 12);
`else
    chk("long_duty_highs", win, 16);
`endif
    en_l = 1'b0;
    step(1);
    chk("long_drop_audio", audio_l, 0);
    chk("long_drop_note", note_l, 0);
    chk("long_drop_playing", playing_l, 0);
    en_l = 1'b1;
    step(1);
    chk("long_restart_playing", playing_l, 1);
    measure_rise(rise);
    check_rise("long_restart_rise", rise);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
